// File: rtl/conv_psum_drain.sv
// Partial-sum drain: accumulates LAYERS partial-sum vectors per pixel, requantizes and
// serializes per-channel bytes. Optional bias input on the first beat: CONV_DRAIN_BIAS_EN.
module conv_psum_drain #(
  parameter int NUM_CH = 11,
  parameter int PSUM_W = 32,
  parameter int LAYERS = 3,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 8,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       psum_valid,
  output logic                       psum_ready,
  input  logic [0:NUM_CH*PSUM_W-1]   psum_data,
`ifdef CONV_DRAIN_BIAS_EN
  input  logic [0:NUM_CH*PSUM_W-1]   bias_data,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int LC_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [LC_W-1:0]         LAST_LAYER = LC_W'(LAYERS - 1);
  localparam logic [IDX_W-1:0]        LAST_CH    = IDX_W'(NUM_CH - 1);
  localparam logic signed [PSUM_W:0]  ROUND      = (PSUM_W+1)'(64'd1 << (SHIFT - 1));
  localparam logic signed [PSUM_W:0]  MAX_OUT    = (PSUM_W+1)'((64'd1 << (OUT_W - 1)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  state_t                    state;
  logic [LC_W-1:0]           layer_cnt;
  logic signed [PSUM_W-1:0]  acc      [NUM_CH];
  logic signed [PSUM_W-1:0]  next_acc [NUM_CH];
  logic [IDX_W-1:0]          next_idx;

  function automatic logic signed [PSUM_W-1:0] sat_add(
    input logic signed [PSUM_W-1:0] a,
    input logic signed [PSUM_W-1:0] b
  );
    logic signed [PSUM_W:0] s;
    s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    if (s[PSUM_W] != s[PSUM_W-1])
      sat_add = s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    else
      sat_add = s[PSUM_W-1:0];
  endfunction

  // Round half up, then ReLU and clamp to the positive half of the signed output range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [PSUM_W-1:0] a);
    logic signed [PSUM_W:0] t;
    logic signed [PSUM_W:0] r;
    t = {a[PSUM_W-1], a} + ROUND;
    r = t >>> SHIFT;
    if (r[PSUM_W])
      requant = '0;
    else if (r > MAX_OUT)
      requant = MAX_OUT[OUT_W-1:0];
    else
      requant = r[OUT_W-1:0];
  endfunction

  assign psum_ready = (state != EMIT);
  assign busy       = (state != IDLE);
  assign next_idx   = out_idx + 1'b1;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      next_acc[k] = acc[k];
      if (layer_cnt == '0) begin
`ifdef CONV_DRAIN_BIAS_EN
        next_acc[k] = sat_add(psum_data[k*PSUM_W +: PSUM_W], bias_data[k*PSUM_W +: PSUM_W]);
`else
        next_acc[k] = psum_data[k*PSUM_W +: PSUM_W];
`endif
      end else begin
        next_acc[k] = sat_add(acc[k], psum_data[k*PSUM_W +: PSUM_W]);
      end
    end
  end

  // The first output word is computed from the freshly accumulated vector so it is
  // valid on the cycle right after the final beat.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state     <= IDLE;
      layer_cnt <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (psum_valid) begin
            acc <= next_acc;
            if (layer_cnt == LAST_LAYER) begin
              layer_cnt <= '0;
              state     <= EMIT;
              out_idx   <= '0;
              out_valid <= 1'b1;
              out_data  <= requant(next_acc[0]);
              out_last  <= (NUM_CH == 1);
            end else begin
              layer_cnt <= layer_cnt + 1'b1;
              state     <= ACCUM;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              state     <= IDLE;
            end else begin
              out_idx   <= next_idx;
              out_data  <= requant(acc[next_idx]);
              out_last  <= (next_idx == LAST_CH);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_psum_drain.sv
// Directed bench for conv_psum_drain: reset, requantization corners, stalls, saturation
// and aborted accumulation, with hand-computed expected words.
module tb_conv_psum_drain;

  localparam int NUM_CH = 11;
  localparam int PSUM_W = 32;

  logic                       clk = 1'b0;
  logic                       rst_b;
  logic                       psum_valid;
  logic                       psum_ready;
  logic [0:NUM_CH*PSUM_W-1]   psum_data;
`ifdef CONV_DRAIN_BIAS_EN
  logic [0:NUM_CH*PSUM_W-1]   bias_data;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [7:0]                 out_data;
  logic [3:0]                 out_idx;
  logic                       out_last;
  logic                       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] obs_data [NUM_CH];
  logic [3:0] obs_idx  [NUM_CH];
  logic       obs_last [NUM_CH];
  logic       obs_timeout;

  conv_psum_drain dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
`ifdef CONV_DRAIN_BIAS_EN
    .bias_data  (bias_data),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < NUM_CH; k++) psum_data[k*PSUM_W +: PSUM_W] = v;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    psum_data[k*PSUM_W +: PSUM_W] = v;
  endtask

  task automatic send_beat();
    int t = 0;
    while (!psum_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!psum_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL beat_wait: psum_ready=%0b after %0d cycles, required 1", psum_ready, t);
    end
    psum_valid = 1'b1;
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask

  // Captures count output transfers with out_ready held high.
  task automatic collect(input int count);
    out_ready   = 1'b1;
    obs_timeout = 1'b0;
    for (int i = 0; i < count; i++) begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!out_valid) begin
        obs_timeout = 1'b1;
        break;
      end
      obs_data[i] = out_data;
      obs_idx[i]  = out_idx;
      obs_last[i] = out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_b      = 1'b1;
    psum_valid = 1'b0;
    out_ready  = 1'b0;
    set_all(32'd0);
`ifdef CONV_DRAIN_BIAS_EN
    bias_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (psum_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_psum_ready: got %0b expected 1", psum_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (out_idx !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", out_idx); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last: got %0b expected 0", out_last); end

    set_all(32'd256);
    repeat (3) send_beat();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (out_idx !== 4'd5) begin n_fail++; $display("[TB] FAIL emit_idx_before_reset: got %0d expected 5", out_idx); end
    rst_b = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midemit_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midemit_busy: got %0b expected 0", busy); end
    n_checks++; if (out_idx !== 4'd0) begin n_fail++; $display("[TB] FAIL midemit_out_idx: got %0d expected 0", out_idx); end
    rst_b = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (psum_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL postreset_psum_ready: got %0b expected 1", psum_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL postreset_out_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    set_all(32'd256);
    repeat (2) send_beat();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_accum: got %0b expected 1", busy); end
    send_beat();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_latency: out_valid got %0b expected 1", out_valid); end
    n_checks++; if (psum_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ready_emit: got %0b expected 0", psum_ready); end
    collect(NUM_CH);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++; if (obs_data[i] !== 8'd3) begin n_fail++; $display("[TB] FAIL basic_data[%0d]: got %0d expected 3", i, obs_data[i]); end
      n_checks++; if (obs_idx[i] !== 4'(i)) begin n_fail++; $display("[TB] FAIL basic_idx[%0d]: got %0d expected %0d", i, obs_idx[i], i); end
      n_checks++; if (obs_last[i] !== (i == NUM_CH - 1)) begin n_fail++; $display("[TB] FAIL basic_last[%0d]: got %0b expected %0b", i, obs_last[i], (i == NUM_CH - 1)); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_valid: got %0b expected 0", out_valid); end
    n_checks++; if (psum_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done_ready: got %0b expected 1", psum_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_requant();
    logic [7:0] expv [NUM_CH];
    expv = '{8'd0, 8'd127, 8'd2, 8'd1, 8'd4, 8'd0, 8'd59, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int b = 0; b < 3; b++) begin
      set_all(32'd0);
      set_ch(0, -32'sd1000);
      set_ch(1, 32'd20000);
      set_ch(2, 32'd128);
      set_ch(3, (b == 0) ? 32'd127 : 32'd128);
      set_ch(4, 32'd300);
      set_ch(5, -32'sd100);
      set_ch(6, 32'd5000);
      send_beat();
    end
    collect(NUM_CH);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL requant_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++; if (obs_data[i] !== expv[i]) begin n_fail++; $display("[TB] FAIL requant_data[%0d]: got %0d expected %0d", i, obs_data[i], expv[i]); end
    end
  endtask

  task automatic test_stall();
    set_all(32'd256);
    repeat (3) send_beat();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_all(32'h7FFF_FFF0);
    for (int c = 0; c < 5; c++) begin
      psum_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_data !== 8'd3) begin n_fail++; $display("[TB] FAIL stall_data[%0d]: got %0d expected 3", c, out_data); end
      n_checks++; if (out_idx !== 4'd4) begin n_fail++; $display("[TB] FAIL stall_idx[%0d]: got %0d expected 4", c, out_idx); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid[%0d]: got %0b expected 1", c, out_valid); end
      n_checks++; if (psum_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready[%0d]: got %0b expected 0", c, psum_ready); end
    end
    psum_valid = 1'b0;
    collect(NUM_CH - 4);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH - 4; i++) begin
      n_checks++; if (obs_data[i] !== 8'd3) begin n_fail++; $display("[TB] FAIL stall_rest_data[%0d]: got %0d expected 3", i, obs_data[i]); end
      n_checks++; if (obs_idx[i] !== 4'(i + 4)) begin n_fail++; $display("[TB] FAIL stall_rest_idx[%0d]: got %0d expected %0d", i, obs_idx[i], i + 4); end
    end
    set_all(32'd512);
    repeat (3) send_beat();
    collect(NUM_CH);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_next_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++; if (obs_data[i] !== 8'd6) begin n_fail++; $display("[TB] FAIL stall_next_data[%0d]: got %0d expected 6", i, obs_data[i]); end
    end
  endtask

  task automatic test_saturation();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < NUM_CH; k++)
        set_ch(k, (k % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0010);
      send_beat();
    end
    collect(NUM_CH);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++; if (obs_data[i] !== ((i % 2 == 0) ? 8'd127 : 8'd0)) begin n_fail++; $display("[TB] FAIL sat_data[%0d]: got %0d expected %0d", i, obs_data[i], (i % 2 == 0) ? 127 : 0); end
    end
  endtask

  task automatic test_abort_accum();
    logic [7:0] expv;
    set_all(32'd10000);
    repeat (2) send_beat();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy: got %0b expected 1", busy); end
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_valid: got %0b expected 0", out_valid); end
    set_all(32'd512);
`ifdef CONV_DRAIN_BIAS_EN
    for (int k = 0; k < NUM_CH; k++) bias_data[k*PSUM_W +: PSUM_W] = -32'sd512;
    expv = 8'd4;
`else
    expv = 8'd6;
`endif
    repeat (3) send_beat();
    collect(NUM_CH);
    n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_timeout: got %0b expected 0", obs_timeout); end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++; if (obs_data[i] !== expv) begin n_fail++; $display("[TB] FAIL abort_data[%0d]: got %0d expected %0d", i, obs_data[i], expv); end
    end
`ifdef CONV_DRAIN_BIAS_EN
    bias_data = '0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant();
    test_stall();
    test_saturation();
    test_abort_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_psum_drain.md
Name: conv_psum_drain

Overview:
Reader/consumer on the output side of the 11-channel convolution multiply-add layer. It captures each 11x32-bit partial-sum vector and accumulates LAYERS successive vectors per output pixel. It then requantizes each channel (round, ReLU, clamp) and serializes the 11 results as 8-bit words over a valid/ready stream to the pooling/FC stage.

Parameters:
NUM_CH, 11, channels per partial-sum vector (index width = 4 bits at default)
PSUM_W, 32, width of each incoming partial sum, signed
LAYERS, 3, partial-sum vectors accumulated per output pixel (>=1)
SHIFT, 8, requantization right-shift amount (>=1)
OUT_W, 8, output word width; result range 0..2^(OUT_W-1)-1

Ports:
clk  in  1  clock, all state on rising edge
rst_b  in  1  reset, asynchronous, active-high (asserted = 1)
psum_valid  in  1  partial-sum vector valid (driven from the layer's registered output strobe)
psum_ready  out  1  drain can accept a vector
psum_data  in  NUM_CH*PSUM_W  packed [0:NUM_CH*PSUM_W-1]; channel k = bits [k*PSUM_W : k*PSUM_W+PSUM_W-1], bit 0 of slice is MSB
out_valid  out  1  serialized result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  requantized result, unsigned magnitude in signed OUT_W range
out_idx  out  4  channel index of out_data
out_last  out  1  high with out_idx = NUM_CH-1
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, layer_cnt=0, out_idx=0, all acc[k]=0, out_valid=0, out_data=0, out_last=0, busy=0; psum_ready=1 once reset deasserts. Reset mid-ACCUM/EMIT discards partial results; no output emitted.
- States: IDLE, ACCUM, EMIT. psum_ready = 1 in IDLE/ACCUM, 0 in EMIT (combinational from state).
- Beat accepted when psum_valid && psum_ready. psum_valid while psum_ready=0 is ignored (not buffered).
- Beat with layer_cnt=0: acc[k] <= sign-extended psum[k] (plus bias, see feature); state->ACCUM.
- Later beats: acc[k] <= sat(acc[k] + psum[k]), signed saturation to PSUM_W bits (no wrap).
- Beat with layer_cnt=LAYERS-1: layer_cnt<=0, state->EMIT, out_idx<=0. LAYERS=1: IDLE goes straight to EMIT on each beat.
- EMIT: out_valid=1 registered, appears cycle after final beat (latency 1 clk from last accepted beat to first output). Output for channel i: r = (acc[i] + 2^(SHIFT-1)) >>> SHIFT, with the add computed one bit wider so it cannot overflow. If r<0 -> 0; if r>2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; else r[OUT_W-1:0].
- Transfer when out_valid && out_ready: out_idx increments. out_data/out_idx/out_last are held stable while out_ready=0.
- Transfer at out_idx=NUM_CH-1 (out_last=1): out_valid<=0, state->IDLE, psum_ready=1 next cycle. 11 outputs minimum 11 cycles.
- No simultaneous accept-and-emit: the next pixel's first beat is accepted only after the last output transfers.

Optional Feature:
CONV_DRAIN_BIAS_EN: when defined, adds port bias_data in NUM_CH*PSUM_W (same packing as psum_data). bias_data is sampled only on the layer_cnt=0 beat: acc[k] <= sat(psum[k] + bias[k]). When undefined, the port does not exist and acc loads psum alone.

Test Plan:
- Reset then idle -> out_valid=0, psum_ready=1, busy=0, out_idx=0; assert rst_b mid-EMIT at out_idx=5 -> out_valid=0 next edge, state IDLE.
- 3 beats, all channels psum=256 -> acc=768 -> 11 outputs value 3, idx 0..10, out_last only on idx 10, first out_valid 1 cycle after 3rd beat.
- Ch0 psum=-1000 x3 -> 0 (ReLU); ch1 psum=20000 x3 (60000) -> 127 (clamp); ch2 psum=128 x3 (384) -> 2 (round half up); ch3 acc=383 -> 1.
- out_ready held 0 for 5 cycles at out_idx=4 -> out_data/out_idx stable, psum_ready=0; psum_valid pulses during stall are dropped, next pixel result unaffected.
- Saturation: psum=0x7FFFFFF0 x3 -> acc=0x7FFFFFFF -> output 127; psum=0x80000010 x3 -> acc=0x80000000 -> output 0.
- Reset after 2 beats of ACCUM, then 3 beats of psum=512 -> outputs 6 (no residue from aborted accumulation); with CONV_DRAIN_BIAS_EN, bias=-512 on beat 0 -> outputs 4.
